// File: rtl/riscp_pkg.sv
// Shared fetch/decode types for the riscp pipeline: default instruction/PC widths
// and the packed instruction-queue entry.
package riscp_pkg;

    localparam int RISCP_INSTR_WIDTH = 16;
    localparam int RISCP_PC_WIDTH    = 16;

    typedef struct packed {
        logic [RISCP_PC_WIDTH-1:0]    pc;
        logic [RISCP_INSTR_WIDTH-1:0] instr;
    } iq_entry_t;

endpackage

// File: rtl/iq_storage.sv
// DEPTH x WIDTH register array for the instruction queue: one write port and one
// asynchronous read port. The array is not reset.
module iq_storage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDR-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ADDR-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: capture the entry at the addressed slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_queue.sv
// DEPTH-entry circular instruction queue with PC tags between fetch and decode.
// Define IQ_BYPASS_EN for the zero-latency empty-queue bypass.
module instr_queue
    import riscp_pkg::*;
#(
    parameter int INSTR_WIDTH = RISCP_INSTR_WIDTH,
    parameter int PC_WIDTH    = RISCP_PC_WIDTH,
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [CNT_WIDTH-1:0]   count
);

    localparam int ADDR    = $clog2(DEPTH);
    localparam int ENTRY_W = PC_WIDTH + INSTR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] ZERO_CNT = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);
    localparam logic [ADDR-1:0]      ONE_PTR  = ADDR'(1);

    logic [ADDR-1:0]      wr_ptr_r;
    logic [ADDR-1:0]      rd_ptr_r;
    logic [CNT_WIDTH-1:0] count_r;

    logic                   in_ready_s;
    logic                   out_valid_s;
    logic                   bypass_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   we_s;
    logic [ENTRY_W-1:0]     rdata_s;
    logic [INSTR_WIDTH-1:0] out_instr_s;
    logic [PC_WIDTH-1:0]    out_pc_s;

    iq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .ADDR  (ADDR)
    ) u_storage (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_ptr_r),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Handshake decode; a full queue refuses pushes even when a pop happens.
    always_comb begin
        in_ready_s = (count_r != FULL_CNT);
`ifdef IQ_BYPASS_EN
        bypass_s   = (count_r == ZERO_CNT) && in_valid && !flush;
`else
        bypass_s   = 1'b0;
`endif
        out_valid_s = (count_r != ZERO_CNT) || bypass_s;
        push_s      = in_valid && in_ready_s;
        pop_s       = out_ready && (count_r != ZERO_CNT);
        // A bypassed instruction taken by decode this cycle is never stored.
        we_s        = push_s && !(bypass_s && out_ready) && !flush;
    end

    // Head presentation; outputs are zero whenever nothing is valid.
    always_comb begin
        out_instr_s = {INSTR_WIDTH{1'b0}};
        out_pc_s    = {PC_WIDTH{1'b0}};
        if (bypass_s) begin
            out_instr_s = in_instr;
            out_pc_s    = in_pc;
        end else if (count_r != ZERO_CNT) begin
            out_instr_s = rdata_s[INSTR_WIDTH-1:0];
            out_pc_s    = rdata_s[ENTRY_W-1:INSTR_WIDTH];
        end else begin
            out_instr_s = {INSTR_WIDTH{1'b0}};
            out_pc_s    = {PC_WIDTH{1'b0}};
        end
    end

    // Pointer and occupancy state; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {ADDR{1'b0}};
            rd_ptr_r <= {ADDR{1'b0}};
            count_r  <= ZERO_CNT;
        end else if (flush) begin
            wr_ptr_r <= {ADDR{1'b0}};
            rd_ptr_r <= {ADDR{1'b0}};
            count_r  <= ZERO_CNT;
        end else begin
            if (we_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            if (we_s && !pop_s) begin
                count_r <= count_r + ONE_CNT;
            end else if (pop_s && !we_s) begin
                count_r <= count_r - ONE_CNT;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_instr = out_instr_s;
    assign out_pc    = out_pc_s;
    assign count     = count_r;

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed scenarios plus random traffic checked
// against a queue-based reference model (follows IQ_BYPASS_EN when defined).
module tb_instr_queue;
    import riscp_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = 16'h0000;
    logic [15:0] in_pc = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    iq_entry_t model_q[$];

    instr_queue #(
        .INSTR_WIDTH (16),
        .PC_WIDTH    (16),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor + scoreboard: sample on the falling edge, compare the head, then
    // retire and record this cycle's handshakes in the model.
    always @(negedge clk) begin
        bit        exp_valid;
        bit        byp;
        bit        acc;
        iq_entry_t head;
        if (!rst) begin
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_instr", 32'(out_instr), 32'd0);
            chk("rst_out_pc", 32'(out_pc), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            model_q.delete();
        end else begin
            exp_valid = (model_q.size() != 0);
            byp = 1'b0;
`ifdef IQ_BYPASS_EN
            if (model_q.size() == 0 && in_valid && !flush) begin
                exp_valid = 1'b1;
                byp = 1'b1;
            end
`endif
            chk("count", 32'(count), 32'(model_q.size()));
            chk("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) begin
                if (byp) begin
                    head.pc = in_pc;
                    head.instr = in_instr;
                end else begin
                    head = model_q[0];
                end
            end else begin
                head = '0;
            end
            chk("out_instr", 32'(out_instr), 32'(head.instr));
            chk("out_pc", 32'(out_pc), 32'(head.pc));
            if (flush) begin
                model_q.delete();
            end else begin
                acc = in_valid && (model_q.size() != DEPTH);
                if (exp_valid && out_ready) begin
                    if (byp) acc = 1'b0;
                    else void'(model_q.pop_front());
                end
                if (acc) model_q.push_back('{pc: in_pc, instr: in_instr});
            end
        end
    end

    task automatic drive(input bit v, input logic [15:0] instr, input logic [15:0] pc,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 16'h0000, ordy, 1'b0);
    endtask

    initial begin
        logic [15:0] base;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1'b0, 2);

        // Fill to full, then a refused fifth push.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 16'(16'h1111 * (i + 1)), 16'(2 * i), 1'b0, 1'b0);
        drive(1'b1, 16'h5555, 16'h0008, 1'b0, 1'b0);
        idle(1'b0, 1);
        // Drain in order.
        idle(1'b1, 6);

        // Wrap-around with count held at 2.
        drive(1'b1, 16'hC000, 16'h0100, 1'b0, 1'b0);
        drive(1'b1, 16'hC001, 16'h0102, 1'b0, 1'b0);
        for (int i = 2; i < 12; i++)
            drive(1'b1, 16'(16'hC000 + i), 16'(16'h0100 + 2 * i), 1'b1, 1'b0);
        idle(1'b1, 3);

        // Flush with 3 entries and a simultaneous push.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 16'(16'hD000 + i), 16'(16'h0200 + 2 * i), 1'b0, 1'b0);
        drive(1'b1, 16'hAAAA, 16'h0300, 1'b0, 1'b1);
        idle(1'b0, 1);
        drive(1'b1, 16'hBBBB, 16'h0400, 1'b0, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 2);

        // Empty queue push with decode ready.
        drive(1'b1, 16'h5A5A, 16'h0500, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Asynchronous reset with 3 entries stored.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 16'(16'hE000 + i), 16'(16'h0600 + 2 * i), 1'b0, 1'b0);
        rst = 1'b0;
        idle(1'b0, 1);
        rst = 1'b1;
        idle(1'b0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            base = 16'($urandom);
            drive(1'($urandom_range(0, 3) != 0), base, 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        idle(1'b1, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
